// File: rtl/alarm_clock_pkg.sv
// alarm_clock_pkg
//   Shared definitions for the alarm-clock key entry logic:
//     - key codes for the two command keys (digits are 0-9, 12-15 unused)
//     - FSM state type and state encodings
//     - default inactivity timeout in one_second ticks
//     - BCD HH:MM range check used when load validation is compiled in
package alarm_clock_pkg;

  localparam logic [3:0] KEY_ALARM = 4'd10;
  localparam logic [3:0] KEY_TIME  = 4'd11;

  localparam int DEFAULT_TIMEOUT_SEC = 10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_ENTRY      = 2'd1;
  localparam state_t ST_SHOW_ALARM = 2'd2;

  // True when t holds a legal 24-hour BCD time 00:00..23:59.
  // Each digit is bounded individually, which also rejects non-BCD nibbles.
  function automatic logic bcd_time_valid(input logic [15:0] t);
    logic ok;
    ok = 1'b1;
    if (t[15:12] > 4'd2) ok = 1'b0;
    if (t[11:8] > 4'd9) ok = 1'b0;
    if ((t[15:12] == 4'd2) && (t[11:8] > 4'd3)) ok = 1'b0;
    if (t[7:4] > 4'd5) ok = 1'b0;
    if (t[3:0] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/key_shift_reg.sv
// key_shift_reg
//   Four-digit BCD entry buffer. Each shift drops the most significant digit
//   and inserts the new digit as the least significant one.
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   synchronous active-low reset, clears the buffer
//   shift    in   insert digit this cycle
//   clear    in   zero the buffer this cycle
//   digit    in   4-bit digit to insert
//   value    out  16-bit buffer contents, [15:12] is the oldest digit
module key_shift_reg (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        shift,
  input  logic        clear,
  input  logic [3:0]  digit,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  // clear together with shift starts a fresh entry: a digit typed in the
  // same cycle the previous entry is being discarded must not be lost.
  always_comb begin
    value_d = value_q;
    if (clear && shift) begin
      value_d = {12'h000, digit};
    end else if (clear) begin
      value_d = 16'h0000;
    end else if (shift) begin
      value_d = {value_q[11:0], digit};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      value_q <= 16'h0000;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl
//   Keypad front end of the alarm clock. Digits are collected into a four
//   digit BCD buffer; ALARM or TIME commits the buffer as a one-cycle load
//   pulse. ALARM pressed while idle shows the alarm time until any key or
//   a timeout. An inactivity timeout abandons entry/display without loading.
//
// Handshake: key is qualified by key_valid for exactly one cycle; there is no
//   back-pressure, every strobe with a code 0..11 is consumed in the cycle it
//   is sampled, codes 12..15 are dropped with no side effect at all.
//
// Optional build feature: define KEY_ENTRY_VALIDATE_EN to range-check the
//   buffer on a load (HH <= 23, MM <= 59, every digit <= 9); an illegal
//   value produces an entry_err pulse instead of the load pulse.
//
// Ports:
//   clock          in   rising-edge clock
//   reset_n        in   synchronous active-low reset
//   one_second     in   one-cycle tick per second
//   key_valid      in   key strobe
//   key[3:0]       in   key code
//   new_time[15:0] out  entered BCD HHMM
//   load_alarm     out  pulse: alarm register loads new_time
//   load_time      out  pulse: current time loads new_time
//   show_new_time  out  display new_time (ENTRY state)
//   show_a         out  display alarm time (SHOW_ALARM state)
//   entry_err      out  pulse: load rejected by range check
//   state_dbg[1:0] out  current FSM state
module key_entry_ctrl
  import alarm_clock_pkg::*;
#(
  parameter int TIMEOUT_SEC = DEFAULT_TIMEOUT_SEC
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        one_second,
  input  logic        key_valid,
  input  logic [3:0]  key,
  output logic [15:0] new_time,
  output logic        load_alarm,
  output logic        load_time,
  output logic        show_new_time,
  output logic        show_a,
  output logic        entry_err,
  output state_t      state_dbg
);

  localparam logic [3:0] TIMEOUT_LIM = 4'(TIMEOUT_SEC);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cnt_inc;
  logic        key_ok;
  logic        key_digit;
  logic        load_is_alarm;
  logic        shift_req;
  logic        tmo_clear;
  logic        load_req;
  logic        time_ok;
  logic        clr_pulse;
  logic        ld_a_q, ld_t_q;
  logic        snt_q, sa_q;

  // Codes 12..15 never count as a key: they neither act nor restart the timer.
  assign key_ok        = key_valid && (key <= KEY_TIME);
  assign key_digit     = key <= 4'd9;
  assign load_is_alarm = key == KEY_ALARM;
  assign cnt_inc       = cnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_req = 1'b0;
    tmo_clear = 1'b0;
    load_req  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 4'd0;
        if (key_ok) begin
          if (key_digit) begin
            shift_req = 1'b1;
            state_d   = ST_ENTRY;
          end else if (load_is_alarm) begin
            state_d = ST_SHOW_ALARM;
          end
        end
      end
      ST_ENTRY: begin
        // A key always wins over a coincident tick.
        if (key_ok) begin
          cnt_d = 4'd0;
          if (key_digit) begin
            shift_req = 1'b1;
          end else begin
            load_req = 1'b1;
            state_d  = ST_IDLE;
          end
        end else if (one_second) begin
          if (cnt_inc == TIMEOUT_LIM) begin
            cnt_d     = 4'd0;
            tmo_clear = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_SHOW_ALARM: begin
        if (key_ok) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else if (one_second) begin
          if (cnt_inc == TIMEOUT_LIM) begin
            cnt_d     = 4'd0;
            tmo_clear = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef KEY_ENTRY_VALIDATE_EN
  logic err_q;

  // new_time still holds the committed value in the cycle the key is sampled.
  assign time_ok = bcd_time_valid(new_time);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= load_req && !time_ok;
    end
  end

  assign entry_err = err_q;
  assign clr_pulse = ld_a_q | ld_t_q | err_q;
`else
  assign time_ok   = 1'b1;
  assign entry_err = 1'b0;
  assign clr_pulse = ld_a_q | ld_t_q;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ld_a_q  <= 1'b0;
      ld_t_q  <= 1'b0;
      snt_q   <= 1'b0;
      sa_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ld_a_q  <= load_req && load_is_alarm && time_ok;
      ld_t_q  <= load_req && !load_is_alarm && time_ok;
      snt_q   <= state_d == ST_ENTRY;
      sa_q    <= state_d == ST_SHOW_ALARM;
    end
  end

  // The buffer is cleared one cycle after a load/error pulse so the pulse
  // cycle still presents the committed value; a timeout clears at once.
  key_shift_reg u_shift (
    .clock   (clock),
    .reset_n (reset_n),
    .shift   (shift_req),
    .clear   (tmo_clear | clr_pulse),
    .digit   (key),
    .value   (new_time)
  );

  assign load_alarm    = ld_a_q;
  assign load_time     = ld_t_q;
  assign show_new_time = snt_q;
  assign show_a        = sa_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// tb_key_entry_ctrl
//   Directed bench for key_entry_ctrl (TIMEOUT_SEC = 10). Expectations for
//   the range check follow KEY_ENTRY_VALIDATE_EN when the bench is built
//   with the same define as the design.
module tb_key_entry_ctrl;
  import alarm_clock_pkg::*;

`ifdef KEY_ENTRY_VALIDATE_EN
  localparam bit VAL = 1'b1;
`else
  localparam bit VAL = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic        one_second;
  logic        key_valid;
  logic [3:0]  key;
  logic [15:0] new_time;
  logic        load_alarm;
  logic        load_time;
  logic        show_new_time;
  logic        show_a;
  logic        entry_err;
  state_t      state_dbg;

  int checks;
  int failures;

  typedef struct {
    logic        rst_n;
    logic        kv;
    logic [3:0]  k;
    logic        tick;
    logic [15:0] nt;
    logic        la;
    logic        lt;
    logic        snt;
    logic        sa;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  key_entry_ctrl #(.TIMEOUT_SEC(10)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .one_second    (one_second),
    .key_valid     (key_valid),
    .key           (key),
    .new_time      (new_time),
    .load_alarm    (load_alarm),
    .load_time     (load_time),
    .show_new_time (show_new_time),
    .show_a        (show_a),
    .entry_err     (entry_err),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- driver ----------------
  // Inputs are held across one rising edge; outputs are then sampled 1ns later.
  task automatic drive(input logic rst, input logic kv, input logic [3:0] k,
                       input logic tick);
    reset_n    = rst;
    key_valid  = kv;
    key        = k;
    one_second = tick;
    @(posedge clock);
    #1;
    reset_n    = 1'b1;
    key_valid  = 1'b0;
    key        = 4'd0;
    one_second = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic rst, input logic kv, input logic [3:0] k,
                     input logic tick, input logic [15:0] nt, input logic la,
                     input logic lt, input logic snt, input logic sa,
                     input logic err);
    vec_t v;
    v.rst_n = rst; v.kv = kv; v.k = k; v.tick = tick;
    v.nt = nt; v.la = la; v.lt = lt; v.snt = snt; v.sa = sa; v.err = err;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] pack_out(input logic [15:0] nt,
      input logic la, input logic lt, input logic snt, input logic sa,
      input logic err);
    return {11'd0, nt, la, lt, snt, sa, err};
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- test ----------------
  initial begin
    logic seen_load;
    checks     = 0;
    failures   = 0;
    reset_n    = 1'b0;
    key_valid  = 1'b0;
    key        = 4'd0;
    one_second = 1'b0;

    //   rst kv key    tick new_time  la lt snt sa err
    add(0, 0, 4'd0,  0, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 0, 4'd0,  0, 16'h0000, 0, 0, 0, 0, 0);
    // 1,2,3,4 TIME
    add(1, 1, 4'd1,  0, 16'h0001, 0, 0, 1, 0, 0);
    add(1, 1, 4'd2,  0, 16'h0012, 0, 0, 1, 0, 0);
    add(1, 1, 4'd3,  0, 16'h0123, 0, 0, 1, 0, 0);
    add(1, 1, 4'd4,  0, 16'h1234, 0, 0, 1, 0, 0);
    add(1, 1, 4'd11, 0, 16'h1234, 0, 1, 0, 0, 0);
    add(1, 0, 4'd0,  0, 16'h0000, 0, 0, 0, 0, 0);
    // 0,7,3,0 ALARM
    add(1, 1, 4'd0,  0, 16'h0000, 0, 0, 1, 0, 0);
    add(1, 1, 4'd7,  0, 16'h0007, 0, 0, 1, 0, 0);
    add(1, 1, 4'd3,  0, 16'h0073, 0, 0, 1, 0, 0);
    add(1, 1, 4'd0,  0, 16'h0730, 0, 0, 1, 0, 0);
    add(1, 1, 4'd10, 0, 16'h0730, 1, 0, 0, 0, 0);
    add(1, 0, 4'd0,  0, 16'h0000, 0, 0, 0, 0, 0);
    // 2,5,0,0 TIME: 25:00 is out of range when validation is built in
    add(1, 1, 4'd2,  0, 16'h0002, 0, 0, 1, 0, 0);
    add(1, 1, 4'd5,  0, 16'h0025, 0, 0, 1, 0, 0);
    add(1, 1, 4'd0,  0, 16'h0250, 0, 0, 1, 0, 0);
    add(1, 1, 4'd0,  0, 16'h2500, 0, 0, 1, 0, 0);
    add(1, 1, 4'd11, 0, 16'h2500, 0, ~VAL, 0, 0, VAL);
    add(1, 0, 4'd0,  0, 16'h0000, 0, 0, 0, 0, 0);
    // five digits drop the oldest; codes 12/15 ignored in ENTRY
    add(1, 1, 4'd1,  0, 16'h0001, 0, 0, 1, 0, 0);
    add(1, 1, 4'd2,  0, 16'h0012, 0, 0, 1, 0, 0);
    add(1, 1, 4'd3,  0, 16'h0123, 0, 0, 1, 0, 0);
    add(1, 1, 4'd4,  0, 16'h1234, 0, 0, 1, 0, 0);
    add(1, 1, 4'd5,  0, 16'h2345, 0, 0, 1, 0, 0);
    add(1, 1, 4'd12, 0, 16'h2345, 0, 0, 1, 0, 0);
    add(1, 1, 4'd15, 0, 16'h2345, 0, 0, 1, 0, 0);
    add(1, 1, 4'd11, 0, 16'h2345, 0, 1, 0, 0, 0);
    add(1, 0, 4'd0,  0, 16'h0000, 0, 0, 0, 0, 0);
    // 19:60 minutes out of range
    add(1, 1, 4'd1,  0, 16'h0001, 0, 0, 1, 0, 0);
    add(1, 1, 4'd9,  0, 16'h0019, 0, 0, 1, 0, 0);
    add(1, 1, 4'd6,  0, 16'h0196, 0, 0, 1, 0, 0);
    add(1, 1, 4'd0,  0, 16'h1960, 0, 0, 1, 0, 0);
    add(1, 1, 4'd10, 0, 16'h1960, ~VAL, 0, 0, 0, VAL);
    add(1, 0, 4'd0,  0, 16'h0000, 0, 0, 0, 0, 0);
    // digit during the load pulse starts a fresh entry
    add(1, 1, 4'd4,  0, 16'h0004, 0, 0, 1, 0, 0);
    add(1, 1, 4'd11, 0, 16'h0004, 0, 1, 0, 0, 0);
    add(1, 1, 4'd7,  0, 16'h0007, 0, 0, 1, 0, 0);
    add(1, 1, 4'd10, 0, 16'h0007, 1, 0, 0, 0, 0);
    add(1, 0, 4'd0,  0, 16'h0000, 0, 0, 0, 0, 0);
    // SHOW_ALARM: code 12 ignored, digit consumed without shifting
    add(1, 1, 4'd11, 0, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 1, 4'd10, 0, 16'h0000, 0, 0, 0, 1, 0);
    add(1, 1, 4'd12, 0, 16'h0000, 0, 0, 0, 1, 0);
    add(1, 1, 4'd5,  0, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 4'd0,  0, 16'h0000, 0, 0, 0, 0, 0);
    // reset aborts entry; key during reset and TIME in IDLE ignored
    add(1, 1, 4'd1,  0, 16'h0001, 0, 0, 1, 0, 0);
    add(1, 1, 4'd2,  0, 16'h0012, 0, 0, 1, 0, 0);
    add(0, 1, 4'd3,  0, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 1, 4'd11, 0, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 4'd0,  0, 16'h0000, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].kv, vecs[i].k, vecs[i].tick);
      chk($sformatf("row%0d", i),
          pack_out(new_time, load_alarm, load_time, show_new_time, show_a,
                   entry_err),
          pack_out(vecs[i].nt, vecs[i].la, vecs[i].lt, vecs[i].snt,
                   vecs[i].sa, vecs[i].err));
    end

    // ALARM in IDLE, then timeout after ten ticks
    drive(1, 1, KEY_ALARM, 0);
    chk("show_alarm_on", {31'd0, show_a}, 32'd1);
    for (int t = 0; t < 9; t++) begin
      drive(1, 0, 4'd0, 1);
      drive(1, 0, 4'd0, 0);
    end
    chk("show_alarm_9_ticks", {31'd0, show_a}, 32'd1);
    drive(1, 0, 4'd0, 1);
    chk("show_alarm_timeout", {31'd0, show_a}, 32'd0);
    chk("show_alarm_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});

    // key 5, 9 ticks, key 6 with tick, 9 ticks, 10th tick times out
    seen_load = 1'b0;
    drive(1, 1, 4'd5, 0);
    chk("entry_state", {30'd0, state_dbg}, {30'd0, ST_ENTRY});
    for (int t = 0; t < 9; t++) begin
      drive(1, 0, 4'd0, 1);
      seen_load |= load_alarm | load_time | entry_err;
    end
    chk("entry_9_ticks", {14'd0, state_dbg, new_time},
        {14'd0, ST_ENTRY, 16'h0005});
    drive(1, 1, 4'd6, 1);
    chk("key_wins_tick", {15'd0, show_new_time, new_time}, {15'd0, 1'b1, 16'h0056});
    for (int t = 0; t < 9; t++) begin
      drive(1, 0, 4'd0, 1);
      seen_load |= load_alarm | load_time | entry_err;
    end
    chk("entry_after_restart", {14'd0, state_dbg, new_time},
        {14'd0, ST_ENTRY, 16'h0056});
    drive(1, 0, 4'd0, 1);
    seen_load |= load_alarm | load_time | entry_err;
    chk("entry_timeout", {13'd0, show_new_time, state_dbg, new_time},
        {13'd0, 1'b0, ST_IDLE, 16'h0000});
    drive(1, 0, 4'd0, 0);
    seen_load |= load_alarm | load_time | entry_err;
    chk("timeout_no_load", {31'd0, seen_load}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_entry_ctrl.md
KEY_ENTRY_CTRL -- requirements
Module: key_entry_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_SEC, default 10, meaning one_second ticks without a key before entry/display is abandoned (range 2..15).
REQ-002 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port one_second  input  1  one-cycle tick per second.
REQ-005 SHALL have port key_valid  input  1  one-cycle strobe qualifying key.
REQ-006 SHALL have port key  input  4  key code: 0-9 digit, 10 ALARM, 11 TIME, 12-15 ignored.
REQ-007 SHALL have port new_time  output  16  four BCD digits, [15:12] hour tens .. [3:0] minute units.
REQ-008 SHALL have port load_alarm  output  1  one-cycle pulse, alarm register loads new_time.
REQ-009 SHALL have port load_time  output  1  one-cycle pulse, current-time counter loads new_time.
REQ-010 SHALL have port show_new_time  output  1  display selects new_time.
REQ-011 SHALL have port show_a  output  1  display mux selects alarm_time over current_time.
REQ-012 SHALL have port entry_err  output  1  one-cycle pulse, rejected load.

Function
REQ-013 SHALL implement FSM states IDLE, ENTRY, SHOW_ALARM; all outputs registered.
REQ-014 SHALL in IDLE on digit key: shift digit into new_time LS nibble (others shift left one nibble, MS digit dropped), go ENTRY.
REQ-015 SHALL in IDLE on ALARM key go SHOW_ALARM; TIME key and codes 12-15 ignored.
REQ-016 SHALL in ENTRY on digit key shift as REQ-014 and stay ENTRY.
REQ-017 SHALL in ENTRY on ALARM key pulse load_alarm, on TIME key pulse load_time, then go IDLE and clear new_time to 0 in the cycle after the pulse.
REQ-018 SHALL assert load pulses in the cycle after key_valid is sampled, with new_time holding the entered value during the pulse.
REQ-019 SHALL drive show_new_time=1 exactly while in ENTRY, show_a=1 exactly while in SHOW_ALARM; never both.
REQ-020 SHALL in SHOW_ALARM return to IDLE on any valid key (key consumed, no other effect).
REQ-021 SHALL keep a timeout counter cleared on entry to ENTRY/SHOW_ALARM and on every valid key, incremented per one_second tick.
REQ-022 SHALL on counter reaching TIMEOUT_SEC go IDLE, clear new_time, no load pulse.
REQ-023 SHALL when key_valid and one_second coincide, process key and clear counter (key wins).
REQ-024 SHALL ignore codes 12-15 in all states without resetting the counter.

Reset
REQ-025 SHALL on reset_n=0 at a clock edge force IDLE, new_time=0, counter=0, all pulse and show outputs 0, aborting any entry in progress.
REQ-026 SHALL ignore key_valid in any cycle with reset_n=0.

Configuration
REQ-027 SHALL with KEY_ENTRY_VALIDATE_EN defined, reject a load when hours>23 or minutes>59 (any BCD digit >9 also invalid): pulse entry_err instead of load, then go IDLE, clear new_time.
REQ-028 SHALL without KEY_ENTRY_VALIDATE_EN perform no range check and tie entry_err to 0.

Structure
REQ-029 SHALL take key codes (KEY_ALARM=10, KEY_TIME=11), state typedef and default TIMEOUT_SEC from shared package alarm_clock_pkg.
REQ-030 SHALL place the 4-digit BCD shift/clear buffer in sub-module key_shift_reg (inputs shift, clear, digit; output 16-bit value).

Verification
REQ-031 SHALL cover: keys 1,2,3,4 then TIME -> new_time=16'h1234, load_time one cycle, show_new_time 1->0, then new_time=0.
REQ-032 SHALL cover: keys 0,7,3,0 then ALARM -> load_alarm pulse with new_time=16'h0730, load_time stays 0.
REQ-033 SHALL cover: ALARM in IDLE -> show_a=1; 10 one_second ticks, no key -> show_a=0, state IDLE.
REQ-034 SHALL cover: key 5 then 9 ticks, key 6 coincident with a tick, 9 ticks -> still ENTRY with new_time=16'h0056; 10th tick -> IDLE, no load.
REQ-035 SHALL cover: with KEY_ENTRY_VALIDATE_EN, keys 2,5,0,0 then TIME -> entry_err pulse, no load_time; without macro -> load_time with 16'h2500.
REQ-036 SHALL cover: keys 1,2 then reset_n=0 one cycle -> all outputs 0, subsequent TIME key ignored in IDLE.
